// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter states, frame sizing and the default baud divider.
// Imported by uart_tx today and by uart_rx later.
package uart_pkg;

  typedef enum logic {
    IDLE         = 1'b0,
    TRANSMITTING = 1'b1
  } tx_state_t;

  // 50 MHz system clock at 19200 baud
  localparam int DEFAULT_BAUD_DIV = 2604;

  // One start bit and one stop bit frame the payload.
  function automatic int frame_bits(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-producer side of the UART transmitter: request strobe, payload, serial line and done flag.
// The master modport is the core logic; the slave modport is the transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic                 trmt;
  logic [DATA_BITS-1:0] tx_data;
  logic                 TX;
  logic                 tx_done;

  modport master (
    output trmt,
    output tx_data,
    input  TX,
    input  tx_done
  );

  modport slave (
    input  trmt,
    input  tx_data,
    output TX,
    output tx_done
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter with synchronous clear and count enable.
// tc pulses on the last cycle of each DIV-cycle period; the counter wraps to zero on that edge.
module uart_baud_cnt #(
  parameter int DIV = 2604
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_r;
  logic         last_s;

  assign last_s = (cnt_r == W'(DIV - 1));
  assign tc     = en & last_s;

  // Count cycles within the current bit period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (en) begin
      if (last_s) begin
        cnt_r <= {W{1'b0}};
      end else begin
        cnt_r <= cnt_r + W'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte on a trmt strobe in IDLE and shifts it out LSB-first.
// TX is bit 0 of the shift register, so the pad is driven straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS);
  localparam int BW         = $clog2(FRAME_BITS + 1);

  tx_state_t             state_r;
  tx_state_t             state_nxt_s;
  logic [FRAME_BITS-1:0] shift_r;
  logic [BW-1:0]         bit_cnt_r;
  logic                  tx_done_r;
  logic                  load_s;
  logic                  shift_s;
  logic                  done_s;
  logic                  baud_en_s;
  logic                  baud_tc_s;

  assign baud_en_s   = (state_r == TRANSMITTING);
  assign bus.TX      = shift_r[0];
  assign bus.tx_done = tx_done_r;

  uart_baud_cnt #(
    .DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load_s),
    .en    (baud_en_s),
    .tc    (baud_tc_s)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and datapath strobes; requests during a frame are dropped, not queued
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    shift_s     = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.trmt) begin
          load_s      = 1'b1;
          state_nxt_s = TRANSMITTING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TRANSMITTING: begin
        if (baud_tc_s) begin
          shift_s = 1'b1;
          if (bit_cnt_r == BW'(FRAME_BITS - 1)) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = TRANSMITTING;
          end
        end else begin
          state_nxt_s = TRANSMITTING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Frame shifter, bit counter and done flag; ones shift in behind the stop bit so TX rests high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r   <= {FRAME_BITS{1'b1}};
      bit_cnt_r <= {BW{1'b0}};
      tx_done_r <= 1'b0;
    end else if (load_s) begin
      shift_r   <= {1'b1, bus.tx_data, 1'b0};
      bit_cnt_r <= {BW{1'b0}};
      tx_done_r <= 1'b0;
    end else if (shift_s) begin
      shift_r   <= {1'b1, shift_r[FRAME_BITS-1:1]};
      bit_cnt_r <= bit_cnt_r + BW'(1);
      tx_done_r <= tx_done_r | done_s;
    end else begin
      shift_r   <= shift_r;
      bit_cnt_r <= bit_cnt_r;
      tx_done_r <= tx_done_r;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a fast-divider instance for frame behaviour and a
// default-divider instance decoded by a mid-bit sampling receive model.
module tb_uart_tx;

  localparam int DIV4 = 4;
  localparam int DIVD = 2604;
  localparam int FB   = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) bus4 ();
  uart_tx_if #(.DATA_BITS(8)) busd ();

  uart_tx #(.DATA_BITS(8), .BAUD_DIV(DIV4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  uart_tx #(.DATA_BITS(8)) dutd (
    .clk   (clk),
    .reset (reset),
    .bus   (busd.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level t cycles after the accepting edge: start, data LSB-first, stop, then idle high.
  function automatic logic exp_bit(input logic [7:0] d, input int t, input int div);
    int b;
    b = t / div;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  // Called just after the accepting edge; ends just after the completion edge.
  task automatic watch4(input logic [7:0] d, input int poke_at, input bit scramble);
    for (int t = 0; t < FB * DIV4; t++) begin
      check_eq("tx_bit", bus4.TX, exp_bit(d, t, DIV4));
      check_eq("done_busy", bus4.tx_done, 1'b0);
      if (scramble) bus4.tx_data = 8'($urandom);
      if (poke_at >= 0) bus4.trmt = (t == poke_at);
      tick();
    end
    check_eq("done_rise", bus4.tx_done, 1'b1);
    check_eq("tx_after_stop", bus4.TX, 1'b1);
  endtask

  task automatic send4(input logic [7:0] d, input int poke_at, input bit scramble);
    bus4.tx_data = d;
    bus4.trmt    = 1'b1;
    tick();
    bus4.trmt    = 1'b0;
    watch4(d, poke_at, scramble);
  endtask

  task automatic idle4(input int n, input logic done_exp);
    for (int i = 0; i < n; i++) begin
      check_eq("idle_tx", bus4.TX, 1'b1);
      check_eq("idle_done", bus4.tx_done, done_exp);
      tick();
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] rx_bits;

    bus4.trmt = 1'b0;
    bus4.tx_data = 8'h00;
    busd.trmt = 1'b0;
    busd.tx_data = 8'h00;

    // reset takes effect before any clock edge
    #2 reset = 1'b1;
    #1;
    check_eq("rst_tx", bus4.TX, 1'b1);
    check_eq("rst_done", bus4.tx_done, 1'b0);
    check_eq("rst_txd", busd.TX, 1'b1);
    check_eq("rst_doned", busd.tx_done, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    idle4(100, 1'b0);

    send4(8'hA5, -1, 1'b0);
    idle4(3, 1'b1);

    // mid-cycle reset clears a raised done flag without a clock edge
    #3 reset = 1'b1;
    #1;
    check_eq("rst_async_done", bus4.tx_done, 1'b0);
    check_eq("rst_async_tx", bus4.TX, 1'b1);
    tick();
    reset = 1'b0;
    tick();

    // second request and data changes mid-frame are ignored
    send4(8'h3C, 11, 1'b1);
    idle4(20, 1'b1);

    // back-to-back with trmt held high
    bus4.tx_data = 8'h00;
    bus4.trmt = 1'b1;
    tick();
    bus4.tx_data = 8'h81;
    watch4(8'h00, -1, 1'b0);
    tick();
    bus4.trmt = 1'b0;
    watch4(8'h81, -1, 1'b0);
    idle4(5, 1'b1);

    // reset at k+17, during data bit 3 of 8'hA5 (a zero on the line)
    bus4.tx_data = 8'hA5;
    bus4.trmt = 1'b1;
    tick();
    bus4.trmt = 1'b0;
    for (int t = 0; t < 17; t++) begin
      check_eq("pre_rst_bit", bus4.TX, exp_bit(8'hA5, t, DIV4));
      tick();
    end
    check_eq("pre_rst_low", bus4.TX, exp_bit(8'hA5, 17, DIV4));
    #3 reset = 1'b1;
    #1;
    check_eq("midrst_tx", bus4.TX, 1'b1);
    check_eq("midrst_done", bus4.tx_done, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    idle4(30, 1'b0);
    send4(8'($urandom), -1, 1'b1);

    // randomized frames with a stray request somewhere in each, including the completion edge
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      send4(d, int'($urandom_range(0, 39)), 1'b1);
      bus4.trmt = 1'b0;
      idle4(int'($urandom_range(1, 4)), 1'b1);
    end

    // default divider, decoded by sampling the middle of each bit period
    busd.tx_data = 8'h55;
    busd.trmt = 1'b1;
    tick();
    busd.trmt = 1'b0;
    rx_bits = 10'h000;
    for (int t = 0; t < FB * DIVD; t++) begin
      if (t % DIVD == DIVD / 2) rx_bits[t / DIVD] = busd.TX;
      if ((t % DIVD == 0) || (t % DIVD == DIVD - 1))
        check_eq("txd_edge", busd.TX, exp_bit(8'h55, t, DIVD));
      if (t == FB * DIVD - 1) check_eq("doned_early", busd.tx_done, 1'b0);
      tick();
    end
    check_eq("rx_start", rx_bits[0], 1'b0);
    check_eq("rx_data", rx_bits[8:1], 8'h55);
    check_eq("rx_stop", rx_bits[9], 1'b1);
    check_eq("doned_rise", busd.tx_done, 1'b1);
    check_eq("txd_idle", busd.TX, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
